pixel_write_queue: RTL

PIXEL_WRITE_QUEUE -- requirements
Module: pixel_write_queue

---
 rtl/pixel_write_queue_pkg.sv | 35 +++
 rtl/pixel_write_queue_if.sv | 28 ++
 rtl/pixel_fifo.sv | 63 ++++++
 rtl/pixel_write_queue.sv | 104 ++++++++++
 4 files changed

// File: rtl/pixel_write_queue_pkg.sv
// Shared types for the pixel write queue: coordinate/colour/address widths,
// screen defaults, FSM encoding and the constant-multiplier address helper.
package pixel_write_queue_pkg;

  localparam int SCREEN_W_DEF = 320;
  localparam int SCREEN_H_DEF = 240;
  localparam int X_W          = 9;
  localparam int Y_W          = 8;
  localparam int COLOR_W      = 12;
  localparam int ADDR_W       = 17;
  localparam int DROP_W       = 16;

  typedef logic [X_W-1:0]     x_t;
  typedef logic [Y_W-1:0]     y_t;
  typedef logic [COLOR_W-1:0] color_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // y*width + x as a sum of shifted copies of y; width is a constant at every
  // call site, so this folds into a fixed adder tree with no multiplier.
  function automatic addr_t pixel_addr(input y_t y, input x_t x, input int width);
    addr_t acc;
    acc = addr_t'(x);
    for (int i = 0; i < ADDR_W; i++) begin
      if (width[i]) acc = acc + (addr_t'(y) << i);
    end
    return acc;
  endfunction

endpackage

// File: rtl/pixel_write_queue_if.sv
// Pixel input, flush handshake and framebuffer write bus of the pixel write queue.
interface pixel_write_queue_if;
  import pixel_write_queue_pkg::*;

  x_t                X_in;
  y_t                Y_in;
  color_t            Color_in;
  logic              writeEn;
  logic              in_ready;
  logic              flush;
  logic              flush_done;
  addr_t             mem_addr;
  color_t            mem_data;
  logic              mem_valid;
  logic              mem_ready;
  logic [DROP_W-1:0] drop_count;

  modport slave (
    input  X_in, Y_in, Color_in, writeEn, flush, mem_ready,
    output in_ready, flush_done, mem_addr, mem_data, mem_valid, drop_count
  );

  modport master (
    output X_in, Y_in, Color_in, writeEn, flush, mem_ready,
    input  in_ready, flush_done, mem_addr, mem_data, mem_valid, drop_count
  );

endinterface

// File: rtl/pixel_fifo.sv
// Show-ahead FIFO: head entry is always visible on data_o; pointers wrap
// modulo DEPTH (power of two) and count_o carries log2(DEPTH)+1 bits.
module pixel_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 29
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_push, do_pop;

  // A push into a full FIFO is legal only when the head leaves in the same cycle.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FULL_CNT) || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/pixel_write_queue.sv
// Pixel write queue: address stage + FIFO + RUN/DRAIN/DONE flush FSM.
// Optional PIXEL_TRANSPARENT_DROP_EN drops colour 12'h000 as transparent.
module pixel_write_queue
  import pixel_write_queue_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = SCREEN_W_DEF,
  parameter int SCREEN_H = SCREEN_H_DEF
) (
  input logic               clk,
  input logic               reset,
  pixel_write_queue_if.slave bus
);

  localparam int CNT_W   = $clog2(DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + COLOR_W;
  localparam logic [CNT_W:0] DEPTH_V = (CNT_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic               stage_valid_q, stage_keep_q;
  addr_t              stage_addr_q;
  color_t             stage_color_q;
  logic [DROP_W-1:0]  drop_count_q, drop_count_d;

  logic [CNT_W-1:0]   fifo_count;
  logic               fifo_empty;
  logic [ENTRY_W-1:0] fifo_head;
  logic [CNT_W:0]     occupancy;
  logic               in_range, keep, accept, push, pop, fifo_drained;

  assign in_range = (int'(bus.X_in) < SCREEN_W) && (int'(bus.Y_in) < SCREEN_H);
`ifdef PIXEL_TRANSPARENT_DROP_EN
  assign keep = in_range && (bus.Color_in != '0);
`else
  assign keep = in_range;
`endif

  // The stage slot is reserved in the budget so its push can never overflow.
  assign occupancy    = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(stage_valid_q);
  assign bus.in_ready = (state_q == ST_RUN) && !reset && (occupancy < DEPTH_V);
  assign accept       = bus.writeEn && bus.in_ready;
  assign push         = stage_valid_q && stage_keep_q;

  assign bus.mem_valid  = !fifo_empty && !reset;
  assign pop            = bus.mem_valid && bus.mem_ready;
  assign {bus.mem_addr, bus.mem_data} = fifo_head;
  assign bus.flush_done = (state_q == ST_DONE);
  assign bus.drop_count = drop_count_q;

  // Empty once this cycle's pop (if any) retires the last entry.
  assign fifo_drained = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:   if (bus.flush) state_d = ST_DRAIN;
      ST_DRAIN: if (!stage_valid_q && fifo_drained) state_d = ST_DONE;
      ST_DONE:  state_d = ST_RUN;
      default:  state_d = ST_RUN;
    endcase
  end

  always_comb begin
    drop_count_d = drop_count_q;
    if (stage_valid_q && !stage_keep_q && (drop_count_q != '1))
      drop_count_d = drop_count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_RUN;
      stage_valid_q <= 1'b0;
      stage_keep_q  <= 1'b0;
      drop_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      stage_valid_q <= accept;
      stage_keep_q  <= keep;
      drop_count_q  <= drop_count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      stage_addr_q  <= pixel_addr(bus.Y_in, bus.X_in, SCREEN_W);
      stage_color_q <= bus.Color_in;
    end
  end

  pixel_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .data_i  ({stage_addr_q, stage_color_q}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

endmodule
